// File: rtl/lsu_mem_master.sv
// Load/store initiator for the single-ported data memory.
// Define LSU_SPLIT_EN to run misaligned accesses as byte beats.
module lsu_mem_master #(
  parameter int ADDR_W     = 12,
  parameter int DATA_LIMIT = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [2:0]        func3,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       data_in,
  input  logic [31:0]       data_out
);

`ifdef LSU_SPLIT_EN
  typedef enum logic [1:0] {
    S_IDLE, S_ACCESS, S_RESP, S_SPLIT
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_ACCESS, S_RESP
  } state_t;
`endif

  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(DATA_LIMIT);

  state_t state_q, state_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        mf3_q, mf3_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       din_q, din_d;
`ifdef LSU_SPLIT_EN
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        beat_q, beat_d;
  logic [31:0]       asm_v;
`endif

  logic [1:0]        size_m1;
  logic [ADDR_W:0]   last_byte;
  logic              legal;
  logic              range_err;
  logic              misalign;
  logic              busy_rd;
  logic              busy_wr;

  function automatic logic [1:0] f3_size_m1(
    input logic [2:0] f
  );
    unique case (f[1:0])
      2'b01:   return 2'd1;
      2'b10:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    size_m1   = f3_size_m1(req_func3);
    last_byte = {1'b0, req_addr}
              + {{(ADDR_W-1){1'b0}}, size_m1};
    range_err = last_byte >= LIMIT;
    legal     = 1'b0;
    unique case (req_func3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
    misalign = (req_func3[1:0] == 2'b01 && req_addr[0])
            || (req_func3[1:0] == 2'b10
                && req_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mf3_d   = mf3_q;
    maddr_d = maddr_q;
    din_d   = din_q;
`ifdef LSU_SPLIT_EN
    f3_d    = f3_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;
    asm_v   = rdata_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          err_d   = 1'b0;
          rdata_d = 32'h0;
`ifdef LSU_SPLIT_EN
          f3_d    = req_func3;
          wdata_d = req_wdata;
`endif
          if (!legal || range_err) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (misalign) begin
`ifdef LSU_SPLIT_EN
            beat_d  = 2'd0;
            maddr_d = req_addr;
            mf3_d   = req_we ? 3'b000 : 3'b100;
            din_d   = {24'h0, req_wdata[7:0]};
            state_d = S_SPLIT;
`else
            err_d   = 1'b1;
            state_d = S_RESP;
`endif
          end else begin
            maddr_d = req_addr;
            mf3_d   = req_func3;
            din_d   = req_wdata;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (!we_q) rdata_d = data_out;
        state_d = S_RESP;
      end
`ifdef LSU_SPLIT_EN
      S_SPLIT: begin
        if (!we_q) begin
          asm_v[{beat_q, 3'b000} +: 8] = data_out[7:0];
          rdata_d = asm_v;
        end
        if (beat_q == f3_size_m1(f3_q)) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (f3_q[1])
              rdata_d = asm_v;
            else if (f3_q[2])
              rdata_d = {16'h0, asm_v[15:0]};
            else
              rdata_d = {{16{asm_v[15]}}, asm_v[15:0]};
          end
        end else begin
          beat_d  = beat_q + 2'd1;
          maddr_d = maddr_q + ADDR_W'(1);
          din_d   = {24'h0,
            wdata_q[{beat_q + 2'd1, 3'b000} +: 8]};
        end
      end
`endif
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      mf3_q   <= 3'b000;
      maddr_q <= '0;
      din_q   <= 32'h0;
`ifdef LSU_SPLIT_EN
      f3_q    <= 3'b000;
      wdata_q <= 32'h0;
      beat_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      mf3_q   <= mf3_d;
      maddr_q <= maddr_d;
      din_q   <= din_d;
`ifdef LSU_SPLIT_EN
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
`endif
    end
  end

  // Strobes are gated by rst so a beat in flight is not committed.
  always_comb begin
`ifdef LSU_SPLIT_EN
    busy_rd = (state_q == S_ACCESS || state_q == S_SPLIT)
            && !we_q;
    busy_wr = (state_q == S_ACCESS || state_q == S_SPLIT)
            && we_q;
`else
    busy_rd = state_q == S_ACCESS && !we_q;
    busy_wr = state_q == S_ACCESS && we_q;
`endif
  end

  assign req_ready  = state_q == S_IDLE;
  assign resp_valid = state_q == S_RESP;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid & err_q;
  assign MemRead    = busy_rd & !rst;
  assign MemWrite   = busy_wr & !rst;
  assign func3      = mf3_q;
  assign addr       = maddr_q;
  assign data_in    = din_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed vector bench for lsu_mem_master with a byte memory model.
// Works with or without LSU_SPLIT_EN defined.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  func3;
  logic [11:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int n_chk = 0;
  int n_fail = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_both = 0;
  logic mem_clr;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(12), .DATA_LIMIT(512)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .func3(func3), .addr(addr),
    .data_in(data_in), .data_out(data_out)
  );

  logic [7:0] mem [0:511];
  logic [31:0] raw;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h11;
    end else if (MemWrite) begin
      for (int k = 0; k < 4; k++)
        if (k < (1 << func3[1:0]) && int'(addr) + k < 512)
          mem[int'(addr) + k] <= data_in[8*k +: 8];
    end
  end

  always_comb begin
    raw = 32'h0;
    for (int k = 0; k < 4; k++)
      if (int'(addr) + k < 512) raw[8*k +: 8] = mem[int'(addr) + k];
    case (func3)
      3'b000:  data_out = {{24{raw[7]}}, raw[7:0]};
      3'b100:  data_out = {24'h0, raw[7:0]};
      3'b001:  data_out = {{16{raw[15]}}, raw[15:0]};
      3'b101:  data_out = {16'h0, raw[15:0]};
      default: data_out = raw;
    endcase
  end

  always @(negedge clk) begin
    if (MemRead) n_rd++;
    if (MemWrite) n_wr++;
    if (MemRead && MemWrite) n_both++;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [11:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(vec_t v, int idx);
    int lat, rd0, wr0, ns;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    rd0 = n_rd;
    wr0 = n_wr;
    req_valid = 1'b1;
    req_we    = v.we;
    req_func3 = v.f3;
    req_addr  = v.a;
    req_wdata = v.wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ns = v.exp_err ? 0 : v.exp_lat - 1;
    chk({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " rdata"}, resp_rdata, v.exp_rd);
    chk({tag, " err"}, {31'h0, resp_err}, {31'h0, v.exp_err});
    chk({tag, " reads"}, n_rd - rd0, v.we ? 0 : ns);
    chk({tag, " writes"}, n_wr - wr0, v.we ? ns : 0);
    @(negedge clk);
    chk({tag, " resp_drop"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, " rdata_zero"}, resp_rdata, 32'h0);
    chk({tag, " ready_again"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_func3 = 3'b000;
    req_addr = 12'h0;
    req_wdata = 32'h0;

    vecs.push_back('{1'b0, 3'b010, 12'h000, 32'h0, 32'h00000011, 1'b0, 2});
    vecs.push_back('{1'b1, 3'b000, 12'h005, 32'h000000AB, 32'h0, 1'b0, 2});
    vecs.push_back('{1'b0, 3'b000, 12'h005, 32'h0, 32'hFFFFFFAB, 1'b0, 2});
    vecs.push_back('{1'b0, 3'b100, 12'h005, 32'h0, 32'h000000AB, 1'b0, 2});
    vecs.push_back('{1'b1, 3'b010, 12'h1FE, 32'hDEADBEEF, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b1, 3'b010, 12'h1FC, 32'h12345678, 32'h0, 1'b0, 2});
    vecs.push_back('{1'b0, 3'b010, 12'h1FC, 32'h0, 32'h12345678, 1'b0, 2});
    vecs.push_back('{1'b0, 3'b001, 12'h1FE, 32'h0, 32'h00001234, 1'b0, 2});
    vecs.push_back('{1'b0, 3'b000, 12'h1FF, 32'h0, 32'h00000012, 1'b0, 2});
    vecs.push_back('{1'b0, 3'b000, 12'h200, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b0, 3'b010, 12'hFFC, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b1, 3'b001, 12'h008, 32'h00008001, 32'h0, 1'b0, 2});
    vecs.push_back('{1'b0, 3'b001, 12'h008, 32'h0, 32'hFFFF8001, 1'b0, 2});
    vecs.push_back('{1'b0, 3'b101, 12'h008, 32'h0, 32'h00008001, 1'b0, 2});
    vecs.push_back('{1'b0, 3'b011, 12'h000, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b1, 3'b100, 12'h010, 32'h55, 32'h0, 1'b1, 1});
`ifdef LSU_SPLIT_EN
    vecs.push_back('{1'b1, 3'b010, 12'h00D, 32'h11223344, 32'h0, 1'b0, 5});
    vecs.push_back('{1'b0, 3'b010, 12'h00D, 32'h0, 32'h11223344, 1'b0, 5});
    vecs.push_back('{1'b0, 3'b001, 12'h00F, 32'h0, 32'h00001122, 1'b0, 3});
    vecs.push_back('{1'b1, 3'b001, 12'h021, 32'h0000BEEF, 32'h0, 1'b0, 3});
    vecs.push_back('{1'b0, 3'b001, 12'h021, 32'h0, 32'hFFFFBEEF, 1'b0, 3});
    vecs.push_back('{1'b0, 3'b101, 12'h021, 32'h0, 32'h0000BEEF, 1'b0, 3});
    vecs.push_back('{1'b0, 3'b010, 12'h1FD, 32'h0, 32'h0, 1'b1, 1});
`else
    vecs.push_back('{1'b0, 3'b001, 12'h003, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b1, 3'b010, 12'h00D, 32'h11223344, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b0, 3'b010, 12'h00E, 32'h0, 32'h0, 1'b1, 1});
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    chk("rst req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst MemRead", {31'h0, MemRead}, 32'h0);
    chk("rst MemWrite", {31'h0, MemWrite}, 32'h0);
    chk("rst func3", {29'h0, func3}, 32'h0);
    chk("rst addr", {20'h0, addr}, 32'h0);
    chk("rst data_in", data_in, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

    // Request held during RESP must wait for the following IDLE cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_func3 = 3'b010;
    req_addr = 12'h000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b access read", {31'h0, MemRead}, 32'h1);
    @(negedge clk);
    chk("b2b resp", {31'h0, resp_valid}, 32'h1);
    chk("b2b rdata", resp_rdata, 32'h00000011);
    req_valid = 1'b1;
    req_func3 = 3'b100;
    req_addr = 12'h005;
    chk("b2b ready in resp", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    chk("b2b ready idle", {31'h0, req_ready}, 32'h1);
    chk("b2b no resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b 2nd read", {31'h0, MemRead}, 32'h1);
    chk("b2b 2nd addr", {20'h0, addr}, 32'h005);
    @(negedge clk);
    chk("b2b 2nd resp", {31'h0, resp_valid}, 32'h1);
    chk("b2b 2nd rdata", resp_rdata, 32'h000000AB);
    @(negedge clk);

    // Reset in the middle of a store.
`ifdef LSU_SPLIT_EN
    req_valid = 1'b1;
    req_we = 1'b1;
    req_func3 = 3'b010;
    req_addr = 12'h031;
    req_wdata = 32'hA1B2C3D4;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid beat0 write", {31'h0, MemWrite}, 32'h1);
    chk("mid beat0 data", data_in, 32'h000000D4);
    @(negedge clk);
    chk("mid beat1 addr", {20'h0, addr}, 32'h032);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid byte0 kept", {24'h0, mem[12'h031]}, 32'hD4);
    chk("mid byte1 clean", {24'h0, mem[12'h032]}, 32'h0);
`else
    req_valid = 1'b1;
    req_we = 1'b1;
    req_func3 = 3'b010;
    req_addr = 12'h040;
    req_wdata = 32'h55667788;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid no write", {24'h0, mem[12'h040]}, 32'h0);
`endif
    chk("mid req_ready", {31'h0, req_ready}, 32'h1);
    chk("mid resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("mid MemWrite", {31'h0, MemWrite}, 32'h0);
    chk("mid addr", {20'h0, addr}, 32'h0);
    chk("mid data_in", data_in, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid no late resp", {31'h0, resp_valid}, 32'h0);
    end

    chk("strobe exclusive", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
